// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter that owns one shared WIDTH-bit register.
// Optional back-to-back burst writes under lock: define ARB_LOCK_EN.
module reg_write_arbiter #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8,
  parameter int IDW   = 2
) (
  input  logic                   clk,
  input  logic                   clear,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] wr_data,
  input  logic [N_REQ-1:0]       lock,
  output logic [N_REQ-1:0]       gnt,
  output logic [N_REQ-1:0]       ack,
  output logic [WIDTH-1:0]       OUT,
  output logic [IDW-1:0]         owner,
  output logic                   busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  state_t           nxt;
  logic [IDW-1:0]   ptr;
  logic [IDW-1:0]   win;
  logic [IDW-1:0]   nxt_ptr;
  logic [IDW:0]     sum;
  logic             found;
  logic             own_req;
  logic             burst;
  logic [WIDTH-1:0] dat [N_REQ];

  for (genvar i = 0; i < N_REQ; i++) begin : g_dat
    assign dat[i] = wr_data[i*WIDTH +: WIDTH];
  end

  assign own_req = req[owner];

`ifdef ARB_LOCK_EN
  assign burst = lock[owner] & own_req;
`else
  logic lock_unused;
  assign lock_unused = ^lock;
  assign burst = 1'b0;
`endif

  // Wrap at N_REQ-1 so non power-of-two sizes never reach unused ids
  assign nxt_ptr = (owner == IDW'(N_REQ-1)) ? '0 : owner + 1'b1;

  // First requester at or after ptr, searching circularly
  always_comb begin
    win   = ptr;
    found = 1'b0;
    sum   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      sum = {1'b0, ptr} + (IDW+1)'(i);
      if (sum >= (IDW+1)'(N_REQ))
        sum = sum - (IDW+1)'(N_REQ);
      if (!found && req[sum[IDW-1:0]]) begin
        found = 1'b1;
        win   = sum[IDW-1:0];
      end
    end
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear)
      state <= IDLE;
    else
      state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    if (|req) nxt = GRANT;
      GRANT:   nxt = own_req ? DONE : IDLE;
      DONE:    nxt = burst ? GRANT : IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    gnt        = '0;
    ack        = '0;
    gnt[owner] = (state == GRANT);
    ack[owner] = (state == DONE);
    busy       = (state != IDLE);
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      owner <= '0;
      ptr   <= '0;
      OUT   <= '0;
    end else begin
      if (state == IDLE && |req)
        owner <= win;
      if (state == GRANT && own_req)
        OUT <= dat[owner];
      if (state == DONE && !burst)
        ptr <= nxt_ptr;
    end
  end

endmodule
